tib_accept: RTL and testbench
=============================

// Module: tib_accept
// PURPOSE
//  Line-input front end of the outer interpreter (eForth ACCEPT in hardware).
//  - Takes a byte stream from the UART receiver, edits it, echoes it, and writes
//    it into the terminal input buffer in SPRAM.
//  - On end-of-line it writes a 0x00 terminator, then holds go high. go drives
//    the outer interpreter's en until that stage reports the line consumed.
// PARAMETERS
//  TIB     'h0   base address of terminal input buffer
//  TIB_SZ  80    buffer bytes, including the 0x00 terminator (max 79 chars)
//  MSZ     8     memory data width
//  ASZ     17    memory address width
// PORTS
//  clk     in   1     clock
//  rst     in   1     asynchronous, active-low reset
//  rx_vld  in   1     receive byte valid
//  rx_dat  in   8     receive byte
//  rx_rdy  out  1     byte accepted when rx_vld&rx_rdy
//  tx_vld  out  1     echo byte valid (held until tx_rdy)
//  tx_dat  out  8     echo byte
//  tx_rdy  in   1     UART transmitter ready
//  mb_own  out  1     block owns memory bus (arbiter select)
//  mb_we   out  1     memory write enable
//  mb_ai   out  ASZ   memory address
//  mb_vi   out  MSZ   memory write data
//  go      out  1     line ready; feeds outer interpreter en
//  done    in   1     outer interpreter finished line (1-cycle pulse)
//  len     out  7     current char count in buffer
//  ovf     out  1     sticky: char dropped on full buffer; cleared on go fall
// BEHAVIOUR
//  Reset values: st=ACC, ptr=0, rx_rdy=0, tx_vld=0, tx_dat=0, mb_own=1,
//    mb_we=0, mb_ai=TIB, mb_vi=0, go=0, ovf=0. rx_rdy rises the cycle after rst.
//  States: ACC -> WR -> ECH -> ACC | ACC -> ECH -> ACC | ACC -> TRM -> ECH -> RUN -> ACC.
//  ACC: rx_rdy=1. A byte is captured on handshake and classified:
//   - 0x20..0x7E, or 0x09 (stored as 0x20):
//     - ptr<TIB_SZ-1: ->WR.
//     - full: drop the byte, ovf=1, echo 0x07, ->ECH.
//   - 0x08 or 0x7F:
//     - ptr>0: ptr--, echo 08,20,08, ->ECH.
//     - ptr==0: ignore, stay in ACC.
//   - 0x0D or 0x0A:
//     - ptr>0: ->TRM.
//     - ptr==0: echo 0D,0A and return to ACC (no go).
//   - Any other byte: ignored.
//  WR: one cycle. mb_we=1, mb_ai=TIB+ptr, mb_vi=byte; ptr++; load echo=byte; ->ECH.
//  TRM: one cycle. mb_we=1, mb_ai=TIB+ptr, mb_vi=0x00; load echo 0D,0A; ->ECH.
//  ECH: rx_rdy=0.
//   - Echo bytes are sent in order; tx_vld=1 with tx_dat stable until tx_rdy.
//   - After the last handshake: ->RUN if entered from TRM, else ->ACC.
//  RUN: go=1, mb_own=0 (bus released to outer), rx_rdy=0 (back-pressure).
//   - On done: go=0, ptr=0, ovf=0, mb_own=1, ->ACC.
//  Latency: printable byte accepted at cycle N gives the write at N+1 and
//    tx_vld at N+2. rx_rdy returns the cycle after the last tx handshake.
//  mb_we is high for exactly one cycle per write, and only while mb_own=1.
//  len==ptr at all times. ptr never exceeds TIB_SZ-1, and a terminator is always
//    written at TIB+ptr.
//  done outside RUN is ignored. rx_vld outside ACC is not accepted; the source holds it.
//  Reset mid-operation: all state returns to reset values. A partial line is
//    discarded; no terminator is written.
//  The echo of BEL while full still goes through ECH; ptr is unchanged.
// STRUCTURE
//  eforth1_pkg: enum tib_sts {ACC,WR,ECH,TRM,RUN}; ASCII constants
//    BS=08, DEL=7F, TAB=09, LF=0A, CR=0D, SPC=20, BEL=07.
//  Sub-module tib_echo: 3-entry echo sequencer (load 1..3 bytes, valid/ready out,
//    last flag). tib_accept holds the FSM, ptr, and the memory bus mux.
// TESTING
//  1. Send "1 2 +",CR with tx_rdy=1:
//     - mem[TIB..TIB+5] = 31,20,32,20,2B,00; echo = 31 20 32 20 2B 0D 0A.
//     - go rises; len=5.
//  2. Send "AB",08,"C",CR:
//     - mem = 41,43,00; echo = 41 42 08 20 08 43 0D 0A; len=2 at go.
//  3. Send 08 at ptr=0, then CR on an empty line:
//     - No write, no go; echo only 0D 0A.
//  4. Send 85 'x' bytes with TIB_SZ=80:
//     - 79 stored; 6 BEL echoes; ovf=1; mem[TIB+79]=00 after CR.
//  5. Hold tx_rdy=0 for 20 cycles mid-echo:
//     - tx_dat stable, rx_rdy=0, no bytes lost.
//     - Pulse done in RUN: go=0 next cycle, ptr=0.
//  6. Assert rst low during ECH and during RUN:
//     - All outputs at reset values asynchronously; the next line starts at TIB.

Source files
------------

// File: rtl/eforth1_pkg.sv
// eforth1_pkg: shared types and constants for the eForth line-input front end.
//   tib_sts  - state encoding of the terminal-input-buffer (ACCEPT) FSM
//   ASCII    - control characters recognised by the line editor
//   helpers  - byte classifiers used by the FSM and the echo loader
package eforth1_pkg;

    typedef enum logic [2:0] {
        ACC,    // waiting for a received byte
        WR,     // writing a character into the buffer
        ECH,    // draining the echo sequencer
        TRM,    // writing the 0x00 line terminator
        RUN     // line handed to the outer interpreter
    } tib_sts;

    localparam logic [7:0] BS  = 8'h08;
    localparam logic [7:0] DEL = 8'h7F;
    localparam logic [7:0] TAB = 8'h09;
    localparam logic [7:0] LF  = 8'h0A;
    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] SPC = 8'h20;
    localparam logic [7:0] BEL = 8'h07;

    // Characters that go into the buffer (TAB is stored as a space).
    function automatic logic is_char(input logic [7:0] b);
        return ((b >= SPC) && (b <= 8'h7E)) || (b == TAB);
    endfunction

    function automatic logic is_rub(input logic [7:0] b);
        return (b == BS) || (b == DEL);
    endfunction

    function automatic logic is_eol(input logic [7:0] b);
        return (b == CR) || (b == LF);
    endfunction

endpackage

// File: rtl/tib_echo.sv
// tib_echo: up to three-byte echo sequencer feeding the UART transmitter.
//   clk, rst           clock, asynchronous active-low reset
//   load               load a new sequence (only issued while idle)
//   load_n             number of bytes in the sequence (1..3)
//   load_b0..load_b2   bytes, sent in that order
//   tx_vld / tx_dat    echo byte valid / data, held stable until tx_rdy
//   tx_rdy             transmitter ready
//   last               the byte currently offered is the final one
module tib_echo (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [1:0] load_n,
    input  logic [7:0] load_b0,
    input  logic [7:0] load_b1,
    input  logic [7:0] load_b2,
    output logic       tx_vld,
    output logic [7:0] tx_dat,
    input  logic       tx_rdy,
    output logic       last
);

    logic [1:0] cnt;
    logic [7:0] b1_q;
    logic [7:0] b2_q;

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= 2'd0;
            tx_dat <= 8'h00;
            b1_q   <= 8'h00;
            b2_q   <= 8'h00;
        end else if (load) begin
            cnt    <= load_n;
            tx_dat <= load_b0;
            b1_q   <= load_b1;
            b2_q   <= load_b2;
        end else if (tx_vld && tx_rdy) begin
            cnt <= cnt - 2'd1;
            // Keep the last byte on tx_dat once the sequence is drained.
            if (cnt > 2'd1) begin
                tx_dat <= b1_q;
                b1_q   <= b2_q;
            end
        end
    end

    assign tx_vld = (cnt != 2'd0);
    assign last   = (cnt == 2'd1);

endmodule

// File: rtl/tib_accept.sv
// tib_accept: eForth ACCEPT in hardware. Receives bytes from the UART,
// applies line editing (backspace, tab, overflow bell), echoes them, stores
// the line in the terminal input buffer and terminates it with 0x00. The
// finished line is signalled on go until the outer interpreter pulses done.
//   clk, rst        clock, asynchronous active-low reset
//   rx_vld/rx_dat   received byte, accepted when rx_vld & rx_rdy
//   rx_rdy          ready for a byte (only in ACC)
//   tx_vld/tx_dat   echo byte to the UART transmitter, tx_rdy handshake
//   mb_own          this block drives the memory bus (arbiter select)
//   mb_we/mb_ai/mb_vi  memory write enable, address, write data
//   go              line complete; drives the outer interpreter enable
//   done            outer interpreter consumed the line (1-cycle pulse)
//   len             characters currently in the buffer
//   ovf             sticky: a character was dropped on a full buffer
module tib_accept
    import eforth1_pkg::*;
#(
    parameter int TIB    = 'h0,
    parameter int TIB_SZ = 80,
    parameter int MSZ    = 8,
    parameter int ASZ    = 17
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           rx_vld,
    input  logic [7:0]     rx_dat,
    output logic           rx_rdy,
    output logic           tx_vld,
    output logic [7:0]     tx_dat,
    input  logic           tx_rdy,
    output logic           mb_own,
    output logic           mb_we,
    output logic [ASZ-1:0] mb_ai,
    output logic [MSZ-1:0] mb_vi,
    output logic           go,
    input  logic           done,
    output logic [6:0]     len,
    output logic           ovf
);

    // Last writable character slot; the slot after it is kept for 0x00.
    localparam logic [6:0] PTR_MAX = 7'(TIB_SZ - 1);

    tib_sts     st;
    logic [6:0] ptr;
    logic [7:0] byte_q;
    logic       from_trm;

    logic       hs;
    logic [7:0] rx_ch;
    logic       room;
    logic [ASZ-1:0] tib_addr;

    logic       ech_load;
    logic [1:0] ech_n;
    logic [7:0] ech_b0;
    logic [7:0] ech_b1;
    logic [7:0] ech_b2;
    logic       ech_last;
    logic       echo_done;

    assign hs        = rx_vld && rx_rdy;
    assign rx_ch     = (rx_dat == TAB) ? SPC : rx_dat;
    assign room      = (ptr < PTR_MAX);
    assign tib_addr  = ASZ'(TIB) + ASZ'(ptr);
    assign echo_done = tx_vld && tx_rdy && ech_last;
    assign len       = ptr;

    // Echo sequence selection; loads on the same edge the FSM enters ECH.
    always_comb begin
        // NOTE: every output gets a default first so no latch is inferred.
        ech_load = 1'b0;
        ech_n    = 2'd1;
        ech_b0   = 8'h00;
        ech_b1   = 8'h00;
        ech_b2   = 8'h00;
        case (st)
            ACC: begin
                if (hs) begin
                    if (is_char(rx_dat)) begin
                        if (!room) begin
                            ech_load = 1'b1;
                            ech_b0   = BEL;
                        end
                    end else if (is_rub(rx_dat)) begin
                        if (ptr != 7'd0) begin
                            ech_load = 1'b1;
                            ech_n    = 2'd3;
                            ech_b0   = BS;
                            ech_b1   = SPC;
                            ech_b2   = BS;
                        end
                    end else if (is_eol(rx_dat)) begin
                        if (ptr == 7'd0) begin
                            ech_load = 1'b1;
                            ech_n    = 2'd2;
                            ech_b0   = CR;
                            ech_b1   = LF;
                        end
                    end
                end
            end
            WR: begin
                ech_load = 1'b1;
                ech_b0   = byte_q;
            end
            TRM: begin
                ech_load = 1'b1;
                ech_n    = 2'd2;
                ech_b0   = CR;
                ech_b1   = LF;
            end
            default: ;
        endcase
    end

    tib_echo u_echo (
        .clk     (clk),
        .rst     (rst),
        .load    (ech_load),
        .load_n  (ech_n),
        .load_b0 (ech_b0),
        .load_b1 (ech_b1),
        .load_b2 (ech_b2),
        .tx_vld  (tx_vld),
        .tx_dat  (tx_dat),
        .tx_rdy  (tx_rdy),
        .last    (ech_last)
    );

    // Main FSM. Bus outputs are registered on the edge entering WR/TRM so
    // the write cycle coincides with the WR/TRM state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st       <= ACC;
            ptr      <= 7'd0;
            byte_q   <= 8'h00;
            from_trm <= 1'b0;
            rx_rdy   <= 1'b0;
            mb_own   <= 1'b1;
            mb_we    <= 1'b0;
            mb_ai    <= ASZ'(TIB);
            mb_vi    <= '0;
            go       <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            mb_we <= 1'b0;
            case (st)
                ACC: begin
                    rx_rdy <= 1'b1;
                    if (hs) begin
                        if (is_char(rx_dat)) begin
                            rx_rdy <= 1'b0;
                            if (room) begin
                                mb_we  <= 1'b1;
                                mb_ai  <= tib_addr;
                                mb_vi  <= MSZ'(rx_ch);
                                byte_q <= rx_ch;
                                st     <= WR;
                            end else begin
                                ovf      <= 1'b1;
                                from_trm <= 1'b0;
                                st       <= ECH;
                            end
                        end else if (is_rub(rx_dat)) begin
                            if (ptr != 7'd0) begin
                                ptr      <= ptr - 7'd1;
                                from_trm <= 1'b0;
                                rx_rdy   <= 1'b0;
                                st       <= ECH;
                            end
                        end else if (is_eol(rx_dat)) begin
                            rx_rdy <= 1'b0;
                            if (ptr != 7'd0) begin
                                mb_we <= 1'b1;
                                mb_ai <= tib_addr;
                                mb_vi <= '0;
                                st    <= TRM;
                            end else begin
                                from_trm <= 1'b0;
                                st       <= ECH;
                            end
                        end
                    end
                end
                WR: begin
                    ptr      <= ptr + 7'd1;
                    from_trm <= 1'b0;
                    st       <= ECH;
                end
                TRM: begin
                    from_trm <= 1'b1;
                    st       <= ECH;
                end
                ECH: begin
                    if (echo_done) begin
                        if (from_trm) begin
                            go     <= 1'b1;
                            mb_own <= 1'b0;
                            st     <= RUN;
                        end else begin
                            rx_rdy <= 1'b1;
                            st     <= ACC;
                        end
                    end
                end
                RUN: begin
                    if (done) begin
                        go     <= 1'b0;
                        ptr    <= 7'd0;
                        ovf    <= 1'b0;
                        mb_own <= 1'b1;
                        rx_rdy <= 1'b1;
                        st     <= ACC;
                    end
                end
                default: st <= ACC;
            endcase
        end
    end

endmodule

// File: tb/tb_tib_accept.sv
// tb_tib_accept: directed self-checking bench for tib_accept with a byte
// memory model on the bus and an echo capture queue.
module tb_tib_accept;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rx_vld = 1'b0;
    logic [7:0]  rx_dat = 8'h00;
    logic        rx_rdy;
    logic        tx_vld;
    logic [7:0]  tx_dat;
    logic        tx_rdy = 1'b1;
    logic        mb_own;
    logic        mb_we;
    logic [16:0] mb_ai;
    logic [7:0]  mb_vi;
    logic        go;
    logic        done = 1'b0;
    logic [6:0]  len;
    logic        ovf;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] mem [0:127];
    logic [7:0] echo_q [$];
    logic [7:0] exp_q  [$];
    int we_cnt  = 0;
    int bus_err = 0;
    int max_len = 0;

    tib_accept dut (
        .clk    (clk),
        .rst    (rst),
        .rx_vld (rx_vld),
        .rx_dat (rx_dat),
        .rx_rdy (rx_rdy),
        .tx_vld (tx_vld),
        .tx_dat (tx_dat),
        .tx_rdy (tx_rdy),
        .mb_own (mb_own),
        .mb_we  (mb_we),
        .mb_ai  (mb_ai),
        .mb_vi  (mb_vi),
        .go     (go),
        .done   (done),
        .len    (len),
        .ovf    (ovf)
    );

    always #5 clk = ~clk;

    // Memory model and echo capture, sampled at the active edge.
    always @(posedge clk) begin
        if (rst) begin
            if (mb_we) begin
                if (!mb_own || mb_ai > 17'd127) bus_err++;
                mem[mb_ai[6:0]] = mb_vi;
                we_cnt++;
            end
            if (tx_vld && tx_rdy) echo_q.push_back(tx_dat);
            if (int'(len) > max_len) max_len = int'(len);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Present a byte and hold it until accepted (bounded).
    task automatic send(input logic [7:0] b);
        bit ok;
        ok = 1'b0;
        @(negedge clk);
        rx_vld = 1'b1;
        rx_dat = b;
        for (int i = 0; i < 300; i++) begin
            if (rx_rdy) begin
                @(posedge clk);
                #1;
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        rx_vld = 1'b0;
        if (!ok) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_go();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (go) break;
        end
        check("go_rise", go, 1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (rx_rdy) break;
        end
        check("rx_rdy_back", rx_rdy, 1);
    endtask

    task automatic pulse_done();
        @(negedge clk);
        done = 1'b1;
        @(posedge clk);
        #1;
        done = 1'b0;
    endtask

    task automatic check_echo(input string tag);
        int n;
        check({tag, "_cnt"}, echo_q.size(), exp_q.size());
        n = (echo_q.size() < exp_q.size()) ? echo_q.size() : exp_q.size();
        for (int i = 0; i < n; i++)
            check($sformatf("%s[%0d]", tag, i), echo_q[i], exp_q[i]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int w0;
        int bels;
        logic [7:0] held;
        int bad;

        for (int i = 0; i < 128; i++) mem[i] = 8'hEE;

        // Reset values
        #12;
        check("rst_rx_rdy", rx_rdy, 0);
        check("rst_tx_vld", tx_vld, 0);
        check("rst_tx_dat", tx_dat, 0);
        check("rst_mb_own", mb_own, 1);
        check("rst_mb_we",  mb_we, 0);
        check("rst_mb_ai",  mb_ai, 0);
        check("rst_mb_vi",  mb_vi, 0);
        check("rst_go",     go, 0);
        check("rst_ovf",    ovf, 0);
        check("rst_len",    len, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rx_rdy_after_rst", rx_rdy, 1);

        // 1: "1 2 +" CR
        echo_q.delete();
        send(8'h31); send(8'h20); send(8'h32); send(8'h20); send(8'h2B); send(8'h0D);
        wait_go();
        check("t1_len", len, 5);
        check("t1_mb_own", mb_own, 0);
        check("t1_rx_rdy", rx_rdy, 0);
        check("t1_m0", mem[0], 8'h31);
        check("t1_m1", mem[1], 8'h20);
        check("t1_m2", mem[2], 8'h32);
        check("t1_m3", mem[3], 8'h20);
        check("t1_m4", mem[4], 8'h2B);
        check("t1_m5", mem[5], 8'h00);
        exp_q = '{8'h31, 8'h20, 8'h32, 8'h20, 8'h2B, 8'h0D, 8'h0A};
        check_echo("t1_echo");
        pulse_done();
        check("t1_go_fall", go, 0);
        check("t1_len_clr", len, 0);
        check("t1_own_back", mb_own, 1);

        // 2: "AB" BS "C" CR, with write/echo latency on the first byte
        echo_q.delete();
        wait_idle();
        rx_vld = 1'b1;
        rx_dat = 8'h41;
        @(posedge clk);
        #1;
        rx_vld = 1'b0;
        check("lat_we_n1", mb_we, 1);
        check("lat_ai_n1", mb_ai, 0);
        check("lat_vi_n1", mb_vi, 8'h41);
        check("lat_txv_n1", tx_vld, 0);
        check("lat_rdy_n1", rx_rdy, 0);
        @(posedge clk);
        #1;
        check("lat_we_n2", mb_we, 0);
        check("lat_txv_n2", tx_vld, 1);
        check("lat_txd_n2", tx_dat, 8'h41);
        send(8'h42);
        pulse_done();   // ignored outside RUN
        check("t2_len_ab", len, 2);
        send(8'h08); send(8'h43); send(8'h0D);
        wait_go();
        check("t2_len", len, 2);
        check("t2_m0", mem[0], 8'h41);
        check("t2_m1", mem[1], 8'h43);
        check("t2_m2", mem[2], 8'h00);
        exp_q = '{8'h41, 8'h42, 8'h08, 8'h20, 8'h08, 8'h43, 8'h0D, 8'h0A};
        check_echo("t2_echo");
        pulse_done();

        // 3: BS on empty line, then CR on empty line
        echo_q.delete();
        w0 = we_cnt;
        send(8'h08);
        send(8'h0D);
        wait_idle();
        repeat (3) @(negedge clk);
        check("t3_no_write", we_cnt - w0, 0);
        check("t3_no_go", go, 0);
        check("t3_len", len, 0);
        exp_q = '{8'h0D, 8'h0A};
        check_echo("t3_echo");

        // 4: 85 'x' bytes overflow the 80-byte buffer
        echo_q.delete();
        for (int i = 0; i < 85; i++) send(8'h78);
        wait_idle();
        check("t4_ovf", ovf, 1);
        check("t4_len_full", len, 79);
        send(8'h0D);
        wait_go();
        check("t4_len", len, 79);
        check("t4_m0", mem[0], 8'h78);
        check("t4_m78", mem[78], 8'h78);
        check("t4_m79", mem[79], 8'h00);
        bels = 0;
        foreach (echo_q[i]) if (echo_q[i] == 8'h07) bels++;
        check("t4_bel_cnt", bels, 6);
        check("t4_echo_cnt", echo_q.size(), 87);
        pulse_done();
        check("t4_ovf_clr", ovf, 0);

        // 5: transmitter stall mid-echo; TAB held by the source meanwhile
        echo_q.delete();
        tx_rdy = 1'b0;
        send(8'h51);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_vld) break;
        end
        check("t5_tx_vld", tx_vld, 1);
        held = tx_dat;
        check("t5_held", held, 8'h51);
        fork
            send(8'h09);
        join_none
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (tx_dat !== held || !tx_vld || rx_rdy) bad++;
        end
        check("t5_stall_stable", bad, 0);
        tx_rdy = 1'b1;
        wait fork;
        send(8'h0D);
        wait_go();
        check("t5_len", len, 2);
        check("t5_m0", mem[0], 8'h51);
        check("t5_m1", mem[1], 8'h20);
        check("t5_m2", mem[2], 8'h00);
        exp_q = '{8'h51, 8'h20, 8'h0D, 8'h0A};
        check_echo("t5_echo");
        pulse_done();
        check("t5_go_fall", go, 0);
        check("t5_ptr_clr", len, 0);

        // 6a: reset during ECH
        echo_q.delete();
        tx_rdy = 1'b0;
        send(8'h5A);
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (tx_vld) break;
        end
        check("t6_in_ech", tx_vld, 1);
        #2;
        rst = 1'b0;
        #1;
        check("t6a_tx_vld", tx_vld, 0);
        check("t6a_tx_dat", tx_dat, 0);
        check("t6a_rx_rdy", rx_rdy, 0);
        check("t6a_len", len, 0);
        check("t6a_mb_own", mb_own, 1);
        @(negedge clk);
        rst = 1'b1;
        tx_rdy = 1'b1;

        // 6b: reset during RUN
        send(8'h4B);
        send(8'h0D);
        wait_go();
        #2;
        rst = 1'b0;
        #1;
        check("t6b_go", go, 0);
        check("t6b_mb_own", mb_own, 1);
        check("t6b_len", len, 0);
        check("t6b_mb_ai", mb_ai, 0);
        @(negedge clk);
        rst = 1'b1;

        // Next line starts at TIB
        echo_q.delete();
        send(8'h4D);
        send(8'h0D);
        wait_go();
        check("t6_m0", mem[0], 8'h4D);
        check("t6_m1", mem[1], 8'h00);
        check("t6_len", len, 1);
        pulse_done();

        check("bus_own_we", bus_err, 0);
        check("len_max", max_len, 79);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
